// File: rtl/ifetch32_hs.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake and
// computes the next PC from the decoder's branch/jump flags.
module ifetch32_hs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic               clock,
    input  logic               reset,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        Instruction,
    output logic               inst_valid,
    output logic [31:0]        PC,
    output logic [31:0]        branch_base_addr,
    output logic [31:0]        link_addr,
    input  logic [31:0]        Addr_result,
    input  logic [31:0]        Read_data_1,
    input  logic               Zero,
    input  logic               Branch,
    input  logic               nBranch,
    input  logic               Jmp,
    input  logic               Jal,
    input  logic               Jrn,
    input  logic               halt
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_next;
    // Keeps imem_req low until the first edge after reset releases.
    logic        run;
    logic        fetch_done;
    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] pc_next;

    assign imem_req         = run && (state == FETCH);
    assign imem_addr        = PC[IMEM_AW+1:2];
    assign inst_valid       = (state == EXEC);
    assign fetch_done       = imem_req && imem_ack;
    assign branch_base_addr = pc_plus4;

    always_comb begin
        pc_plus4    = PC + 32'd4;
        jump_target = {pc_plus4[31:28], Instruction[25:0], 2'b00};
        taken       = (Branch && Zero) || (nBranch && !Zero);
        if (Jrn) begin
            pc_next = Read_data_1;
        end else if (Jmp || Jal) begin
            pc_next = jump_target;
        end else if (taken) begin
            pc_next = Addr_result;
        end else begin
            pc_next = pc_plus4;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:   if (fetch_done) state_next = EXEC;
            EXEC:    state_next = halt ? HALTED : FETCH;
            HALTED:  if (!halt) state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= FETCH;
            run         <= 1'b0;
            PC          <= RESET_PC;
            Instruction <= 32'h0;
            link_addr   <= 32'h0;
        end else begin
            run   <= 1'b1;
            state <= state_next;
            if (fetch_done) begin
                Instruction <= imem_rdata;
            end
            if (state == EXEC) begin
                PC <= pc_next & ~32'h3;
                if (Jal) begin
                    link_addr <= pc_plus4;
                end
            end
        end
    end

endmodule

// File: tb/tb_ifetch32_hs.sv
// Bench for ifetch32_hs: directed scenarios plus randomized instructions checked
// against a transaction-level next-PC model.
module tb_ifetch32_hs;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] Instruction;
    logic        inst_valid;
    logic [31:0] PC;
    logic [31:0] branch_base_addr;
    logic [31:0] link_addr;
    logic [31:0] Addr_result = 32'h0;
    logic [31:0] Read_data_1 = 32'h0;
    logic        Zero = 1'b0;
    logic        Branch = 1'b0;
    logic        nBranch = 1'b0;
    logic        Jmp = 1'b0;
    logic        Jal = 1'b0;
    logic        Jrn = 1'b0;
    logic        halt = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_pc   = 32'h0;
    logic [31:0] exp_link = 32'h0;

    ifetch32_hs #(.RESET_PC(32'h0000_0000), .IMEM_AW(14)) dut (
        .clock            (clock),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .Instruction      (Instruction),
        .inst_valid       (inst_valid),
        .PC               (PC),
        .branch_base_addr (branch_base_addr),
        .link_addr        (link_addr),
        .Addr_result      (Addr_result),
        .Read_data_1      (Read_data_1),
        .Zero             (Zero),
        .Branch           (Branch),
        .nBranch          (nBranch),
        .Jmp              (Jmp),
        .Jal              (Jal),
        .Jrn              (Jrn),
        .halt             (halt)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural next-PC rule, straight from the ISA description.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                               input logic jrn, input logic jmp, input logic jal,
                                               input logic br, input logic nbr, input logic z,
                                               input logic [31:0] ar, input logic [31:0] rd1);
        logic [31:0] seq;
        seq = pc + 32'd4;
        if (jrn) return rd1 & 32'hFFFF_FFFC;
        if (jmp || jal) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
        if ((br && z) || (nbr && !z)) return ar & 32'hFFFF_FFFC;
        return seq;
    endfunction

    // One instruction: fetch with 'waits' wait cycles, execute with the given flags.
    // Entered and left at the start of a FETCH cycle with the request up.
    task automatic run_instr(input int waits, input logic [31:0] word, input logic jrn,
                             input logic jmp, input logic jal, input logic br, input logic nbr,
                             input logic z, input logic [31:0] ar, input logic [31:0] rd1,
                             input logic hlt);
        logic [31:0] nxt;
        halt = hlt;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, exp_pc[15:2]);
        check("fetch_pc", PC, exp_pc);
        check("fetch_valid", inst_valid, 0);
        for (int i = 0; i < waits; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            tick();
            check("wait_req", imem_req, 1);
            check("wait_addr", imem_addr, exp_pc[15:2]);
            check("wait_valid", inst_valid, 0);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        // Ack during EXEC must be ignored.
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom;
        check("exec_valid", inst_valid, 1);
        check("exec_req", imem_req, 0);
        check("exec_inst", Instruction, word);
        check("exec_base", branch_base_addr, exp_pc + 32'd4);
        Jrn = jrn; Jmp = jmp; Jal = jal; Branch = br; nBranch = nbr; Zero = z;
        Addr_result = ar; Read_data_1 = rd1;
        nxt = model_next(exp_pc, word, jrn, jmp, jal, br, nbr, z, ar, rd1);
        if (jal) exp_link = exp_pc + 32'd4;
        exp_pc = nxt;
        tick();
        Jrn = 0; Jmp = 0; Jal = 0; Branch = 0; nBranch = 0; Zero = 0;
        imem_ack = 1'b0;
        check("next_pc", PC, exp_pc);
        check("link", link_addr, exp_link);
        check("inst_hold", Instruction, word);
        check("post_valid", inst_valid, 0);
        if (hlt) begin
            check("halt_req", imem_req, 0);
            imem_ack = 1'b1;
            tick();
            imem_ack = 1'b0;
            check("halt_req2", imem_req, 0);
            check("halt_valid", inst_valid, 0);
            check("halt_pc", PC, exp_pc);
            check("halt_inst", Instruction, word);
            halt = 1'b0;
            tick();
        end
    endtask

    initial begin
        logic [31:0] w;
        logic        fl_jrn, fl_jmp, fl_jal, fl_br, fl_nbr, fl_z, fl_h;

        // Reset state
        repeat (2) tick();
        check("rst_pc", PC, 32'h0);
        check("rst_inst", Instruction, 32'h0);
        check("rst_valid", inst_valid, 0);
        check("rst_link", link_addr, 32'h0);
        check("rst_req", imem_req, 0);
        reset    = 1'b1;
        imem_ack = 1'b1;
        #1;
        check("rel_req", imem_req, 0);
        tick();
        imem_ack = 1'b0;
        check("first_valid", inst_valid, 0);

        // Zero-wait sequential fetch 0,4,8,C
        run_instr(0, 32'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 32'h0000_0002, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(0, 32'h0000_0003, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_instr(3, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Conditional branches at 0x10
        run_instr(0, 32'h1000_0000, 0, 0, 0, 1, 0, 1, 32'h40, 0, 0);
        run_instr(1, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 0);
        run_instr(0, 32'h1000_0000, 0, 0, 0, 1, 0, 0, 32'h40, 0, 0);
        run_instr(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h10, 0);
        run_instr(2, 32'h1400_0000, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0);
        // Jump and link, then jr with misaligned target
        run_instr(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h2000_0008, 0);
        run_instr(0, 32'h0C00_0100, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        run_instr(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h2000_000E, 0);
        // Halt while wrapping past the top of memory
        run_instr(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0);
        run_instr(1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check("resume_addr", imem_addr, 14'h0);

        // Randomized instruction stream
        for (int k = 0; k < 60; k++) begin
            w      = $urandom;
            fl_jrn = ($urandom_range(0, 3) == 0);
            fl_jmp = ($urandom_range(0, 3) == 0);
            fl_jal = ($urandom_range(0, 3) == 0);
            fl_br  = ($urandom_range(0, 2) == 0);
            fl_nbr = ($urandom_range(0, 2) == 0);
            fl_z   = 1'($urandom_range(0, 1));
            fl_h   = ($urandom_range(0, 7) == 0);
            run_instr($urandom_range(0, 3), w, fl_jrn, fl_jmp, fl_jal, fl_br, fl_nbr, fl_z,
                      $urandom, $urandom, fl_h);
        end

        // Reset during a wait cycle at 0x24
        run_instr(0, 32'h0, 1, 0, 0, 0, 0, 0, 0, 32'h24, 0);
        imem_ack = 1'b0;
        tick();
        check("mid_req", imem_req, 1);
        check("mid_pc", PC, 32'h24);
        #2;
        reset = 1'b0;
        #1;
        check("arst_req", imem_req, 0);
        check("arst_pc", PC, 32'h0);
        check("arst_link", link_addr, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        exp_pc   = 32'h0;
        exp_link = 32'h0;
        check("rerun_req", imem_req, 1);
        check("rerun_addr", imem_addr, 14'h0);
        run_instr(0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rerun_pc", PC, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
